// File: rtl/lfsr_scramble_rng.sv
// Multi-channel Fibonacci LFSR random word generator with per-channel bit-permutation
// scrambling and a valid/ready output. Macro RNG_WORD_COUNT_EN builds the handshake counter.
module lfsr_scramble_rng #(
  parameter int unsigned      WIDTH  = 25,
  parameter int unsigned      NUM_CH = 2,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(25'h1200000),
  parameter int unsigned      STRIDE = 7,
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(25'h1ACE5)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    enable,
  input  logic                    load_seed,
  input  logic [WIDTH-1:0]        seed_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [31:0]             word_count
);

  localparam int unsigned DW = NUM_CH * WIDTH;

  // Rotate left by k bit positions (k taken modulo WIDTH).
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] s, input int unsigned k);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      r[(j + k) % WIDTH] = s[j];
    end
    return r;
  endfunction

  logic              r_valid;
  logic [DW-1:0]     r_data;
  logic [DW-1:0]     w_perm;
  logic [WIDTH-1:0]  w_seed;
  logic              w_adv;

  // A zero seed would lock the LFSR, so it falls back to SEED.
  assign w_seed = (seed_in == '0) ? SEED : seed_in;
  assign w_adv  = enable & ~load_seed & (~r_valid | out_ready);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned      ROT       = c % WIDTH;
    localparam logic [WIDTH-1:0] RST_STATE = rotl(SEED, ROT);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed_rot;

    assign w_next     = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
    assign w_seed_rot = rotl(w_seed, ROT);

    // Stride permutation; channel offset c decorrelates channels sharing one stride.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int unsigned IDX = (i * STRIDE + c) % WIDTH;
      assign w_perm[c*WIDTH + i] = r_state[IDX];
    end

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        r_state <= RST_STATE;
      end else if (load_seed) begin
        r_state <= w_seed_rot;
      end else if (w_adv) begin
        r_state <= w_next;
      end
    end
  end

  // Output word register: reload discards any pending word.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load_seed) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= 1'b1;
      r_data  <= w_perm;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

`ifdef RNG_WORD_COUNT_EN
  logic [31:0] r_count;

  // Counts every accepted word, including one accepted during a seed load.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (r_valid && out_ready) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign word_count = r_count;
`else
  assign word_count = 32'h0;
`endif

endmodule

// File: tb/tb_lfsr_scramble_rng.sv
// Scoreboard bench for lfsr_scramble_rng at default parameters; expected words come
// from a behavioural LFSR/permutation model and are queued when an advance is driven.
module tb_lfsr_scramble_rng;

  localparam int unsigned W      = 25;
  localparam int unsigned NC     = 2;
  localparam int unsigned DW     = NC * W;
  localparam logic [W-1:0] M_TAPS = 25'h1200000;
  localparam logic [W-1:0] M_SEED = 25'h1ACE5;
  localparam int unsigned  M_STR  = 7;

  logic          Clk;
  logic          Reset_n;
  logic          enable;
  logic          load_seed;
  logic [W-1:0]  seed_in;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [31:0]   word_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  m_state [NC];
  logic          m_valid;
  logic [31:0]   m_cnt;
  logic [DW-1:0] sb_q [$];

  lfsr_scramble_rng dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .enable    (enable),
    .load_seed (load_seed),
    .seed_in   (seed_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .word_count(word_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_step(input logic [W-1:0] s);
    logic fb;
    fb = 1'b0;
    for (int j = 0; j < W; j++) if (M_TAPS[j]) fb = fb ^ s[j];
    return {s[W-2:0], fb};
  endfunction

  function automatic logic [W-1:0] m_perm(input logic [W-1:0] s, input int c);
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) p[i] = s[(i * M_STR + c) % W];
    return p;
  endfunction

  function automatic logic [W-1:0] m_rotl(input logic [W-1:0] s, input int k);
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) r[(j + k) % W] = s[j];
    return r;
  endfunction

  function automatic logic [DW-1:0] m_word();
    logic [DW-1:0] w;
    for (int c = 0; c < NC; c++) w[c*W +: W] = m_perm(m_state[c], c);
    return w;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef RNG_WORD_COUNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  // One clock: drive inputs, check current outputs, step the model, advance to edge+1.
  task automatic cycle(input logic en, input logic ld, input logic [W-1:0] sd, input logic rdy);
    logic [DW-1:0] exp_w;
    logic [W-1:0]  s;
    enable    = en;
    load_seed = ld;
    seed_in   = sd;
    out_ready = rdy;
    chk("valid", 64'(out_valid), 64'(m_valid));
    chk("count", 64'(word_count), 64'(exp_cnt()));
    if (m_valid && rdy) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 64'(0), 64'(1));
      end else begin
        exp_w = sb_q.pop_front();
        chk("data", 64'(out_data), 64'(exp_w));
      end
      m_cnt++;
    end
    if (ld) begin
      s = (sd == '0) ? M_SEED : sd;
      for (int c = 0; c < NC; c++) m_state[c] = m_rotl(s, c);
      m_valid = 1'b0;
      sb_q.delete();
    end else if (en && (!m_valid || rdy)) begin
      sb_q.push_back(m_word());
      for (int c = 0; c < NC; c++) m_state[c] = m_step(m_state[c]);
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge Clk);
    #1;
  endtask

  // Reset with load/advance requests active to show that reset overrides them.
  task automatic do_reset();
    Reset_n   = 1'b0;
    enable    = 1'b1;
    load_seed = 1'b1;
    seed_in   = 25'h5;
    out_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    for (int c = 0; c < NC; c++) m_state[c] = m_rotl(M_SEED, c);
    m_valid = 1'b0;
    m_cnt   = '0;
    sb_q.delete();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_count", 64'(word_count), 64'(0));
    Reset_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [31:0]   cnt_before;
    int            guard;
    Reset_n   = 1'b1;
    enable    = 1'b0;
    load_seed = 1'b0;
    seed_in   = '0;
    out_ready = 1'b0;
    m_cnt     = '0;
    m_valid   = 1'b0;
    @(posedge Clk);
    #1;
    do_reset();

    // First word after reset is perm of the reset seed.
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("first_ch0", 64'(out_data[W-1:0]), 64'(m_perm(M_SEED, 0)));
    chk("first_ch1", 64'(out_data[2*W-1:W]), 64'(m_perm(m_rotl(M_SEED, 1), 1)));

    // Seed of 1: known first and second words.
    cycle(1'b0, 1'b1, 25'h1, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("seed1_w1_ch0", 64'(out_data[W-1:0]), 64'(25'h0000001));
    chk("seed1_w1_ch1", 64'(out_data[2*W-1:W]), 64'(25'h0000001));
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("seed1_w2_ch0", 64'(out_data[W-1:0]), 64'(25'h0040000));
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

    // Zero seed falls back to the reset sequence.
    cycle(1'b0, 1'b1, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("seed0_ch0", 64'(out_data[W-1:0]), 64'(m_perm(M_SEED, 0)));
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);

    // Backpressure: word holds for 10 cycles, then sequence continues unskipped.
    held = sb_q[0];
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      chk("hold_data", 64'(out_data), 64'(held));
    end
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

    // Load while a word is stalled: dropped, count unchanged.
    cycle(1'b1, 1'b0, '0, 1'b0);
    cnt_before = m_cnt;
    cycle(1'b0, 1'b1, 25'h3, 1'b0);
    chk("ld_stall_valid", 64'(out_valid), 64'(0));
    chk("ld_stall_cnt", 64'(m_cnt), 64'(cnt_before));
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b1);

    // Mid-stream reset discards the pending word.
    cycle(1'b1, 1'b0, '0, 1'b0);
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b1);

    // 100 accepted handshakes with random gaps and backpressure.
    do_reset();
    guard = 0;
    while (m_cnt != 32'd100 && guard < 2000) begin
      if (m_valid && m_cnt == 32'd99)
        cycle(1'b0, 1'b0, '0, 1'b1);
      else
        cycle(1'($urandom_range(0, 3) != 0), 1'b0, '0, 1'($urandom_range(0, 2) != 0));
      guard++;
    end
    chk("hs_guard", 64'(m_cnt), 64'(100));
    cycle(1'b0, 1'b0, '0, 1'b0);
`ifdef RNG_WORD_COUNT_EN
    chk("count_100", 64'(word_count), 64'(100));
`else
    chk("count_100", 64'(word_count), 64'(0));
`endif

    // Random mix including occasional reloads.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 30) == 0)
        cycle(1'b1, 1'b1, W'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom_range(0, 1)));
      else
        cycle(1'($urandom_range(0, 4) != 0), 1'b0, '0, 1'($urandom_range(0, 3) != 0));
    end
    cycle(1'b0, 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_scramble_rng.md
LFSR_SCRAMBLE_RNG -- requirements
Module: lfsr_scramble_rng

Interface
REQ-001 SHALL provide parameter WIDTH, default 25, meaning LFSR state and output word width per channel (legal 4..64).
REQ-002 SHALL provide parameter NUM_CH, default 2, meaning number of independent LFSR+scrambler channels (legal 1..8).
REQ-003 SHALL provide parameter TAPS, default 25'h1200000, meaning feedback mask (x^25+x^22+1).
REQ-004 SHALL provide parameter STRIDE, default 7, meaning permutation stride; gcd(STRIDE, WIDTH) must be 1.
REQ-005 SHALL provide parameter SEED, default 25'h1ACE5, meaning nonzero reset/fallback seed.
REQ-006 SHALL provide port Clk  input  1  sole clock, rising edge.
REQ-007 SHALL provide port Reset_n  input  1  reset; synchronous, active-low.
REQ-008 SHALL provide port enable  input  1  request generation of new words.
REQ-009 SHALL provide port load_seed  input  1  one-cycle seed load strobe.
REQ-010 SHALL provide port seed_in  input  WIDTH  seed value sampled on load_seed.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts out_data.
REQ-012 SHALL provide port out_valid  output  1  out_data holds an unconsumed word set.
REQ-013 SHALL provide port out_data  output  NUM_CH*WIDTH  channel c in bits [c*WIDTH +: WIDTH].
REQ-014 SHALL provide port word_count  output  32  accepted-handshake count.

Function
REQ-015 Per-channel step SHALL be: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
REQ-016 Scramble of channel c SHALL be: perm[i] = state[(i*STRIDE + c) mod WIDTH], for i = 0..WIDTH-1. It is purely combinational from the current state.
REQ-017 An advance SHALL occur when enable=1, load_seed=0 and (out_valid=0 or out_ready=1).
REQ-018 On an advance, all channels SHALL update together:
- out_data <= perm(state);
- state <= next;
- out_valid <= 1.
REQ-019 Latency SHALL be one cycle: a word set appears on out_valid the edge after the advance cycle.
REQ-020 When there is no advance and out_ready=1, out_valid SHALL go to 0. out_data keeps its last value.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_valid and all states SHALL hold stable (no drops, no advances).
REQ-022 On load_seed=1, the following SHALL apply:
- state_c <= rotate-left(s, c), where s = seed_in, or s = SEED if seed_in == 0;
- out_valid <= 0;
- load_seed has priority over an advance and over a pending word, which is discarded.
REQ-023 word_count SHALL increment by 1 on every cycle with out_valid=1 and out_ready=1, including a load_seed cycle. It wraps from 32'hFFFFFFFF to 0.
REQ-024 State SHALL never become zero. A zero seed is replaced per REQ-022, and a nonzero state with a primitive TAPS never reaches zero.

Reset
REQ-025 While Reset_n=0 at a rising Clk edge, the following SHALL apply:
- state_c <= rotate-left(SEED, c);
- out_valid <= 0;
- out_data <= 0;
- word_count <= 0.
REQ-026 Reset SHALL override load_seed and any advance. A reset mid-stream SHALL discard the pending word.

Configuration
REQ-027 When macro RNG_WORD_COUNT_EN is defined, the word_count counter SHALL be built per REQ-023.
REQ-028 When RNG_WORD_COUNT_EN is undefined, the port SHALL still exist and be tied to 32'h0, with no counter logic. All other behaviour SHALL be identical.

Verification
REQ-029 Reset with default parameters, out_ready=1, enable=1 for one cycle -> next cycle out_valid=1, out_data channel 0 = perm0(25'h1ACE5), and state advanced once.
REQ-030 load_seed=1, seed_in=25'h1, then enable=1, out_ready=1 -> the following checks SHALL pass:
- first word: ch0 = 25'h0000001, ch1 = 25'h0000001;
- second word: ch0 = 25'h0040000.
REQ-031 load_seed=1 with seed_in=0 -> subsequent words are identical to those produced after reset.
REQ-032 Hold out_ready=0 for 10 cycles with enable=1 after the first word -> out_data is unchanged and out_valid=1. Raising out_ready delivers the next sequence word with no skip.
REQ-033 Pulse load_seed while out_valid=1 and out_ready=0 -> out_valid=0 next cycle and word_count is unchanged.
REQ-034 100 accepted handshakes -> word_count=100 with RNG_WORD_COUNT_EN defined, and 0 without it.
